// File: rtl/dea_pkg.sv
// Shared definitions for the encryption design's framed UART link.
// The transmitter uses them now; the receive-side parser will share them later.
package dea_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_REQ,
    ST_WAIT_LO,
    ST_FINISH
  } frame_tx_state_t;

  localparam int          DEA_MAX_LEN  = 100;
  localparam logic [13:0] DEA_UART_DIV = 14'd9999;

endpackage

// File: rtl/dea_frame_tx.sv
// Length-prefixed frame transmitter: header, payload read from the result buffer,
// then an optional XOR checksum, each byte handed to UART_Sender via tx_send/tx_busy.
module dea_frame_tx
  import dea_pkg::*;
#(
  parameter int             MAX_LEN       = DEA_MAX_LEN,
  parameter bit             SEND_CHECKSUM = 1'b1,
  parameter int             TO_W          = 16,
  parameter logic [TO_W-1:0] TIMEOUT      = 16'd50000
) (
  input  logic       Clk_100M,
  input  logic       Reset,
  input  logic       start,
  input  logic [7:0] length,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic [7:0] tx_data,
  output logic       tx_send,
  input  logic       tx_busy,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [8:0]      MAX_LEN_W = 9'(MAX_LEN);
  localparam logic [TO_W-1:0] TO_LAST   = TIMEOUT - 1'b1;

  frame_tx_state_t r_state, w_state_next;
  logic [7:0]      r_len, w_len_next;
  logic [7:0]      r_cnt, w_cnt_next;
  logic [7:0]      r_csum, w_csum_next;
  logic            r_cs_sent, w_cs_sent_next;
  logic [TO_W-1:0] r_to_cnt, w_to_cnt_next;
  logic [7:0]      r_rd_addr, w_rd_addr_next;
  logic [7:0]      r_tx_data, w_tx_data_next;
  logic            r_tx_send, w_tx_send_next;
  logic            r_busy, w_busy_next;
  logic            r_done, w_done_next;
  logic            r_err, w_err_next;
  logic            w_len_bad;

  assign w_len_bad = {1'b0, length} > MAX_LEN_W;

  always_ff @(posedge Clk_100M) begin
    if (Reset) begin
      r_state   <= ST_IDLE;
      r_len     <= '0;
      r_cnt     <= '0;
      r_csum    <= '0;
      r_cs_sent <= 1'b0;
      r_to_cnt  <= '0;
      r_rd_addr <= '0;
      r_tx_data <= '0;
      r_tx_send <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_len     <= w_len_next;
      r_cnt     <= w_cnt_next;
      r_csum    <= w_csum_next;
      r_cs_sent <= w_cs_sent_next;
      r_to_cnt  <= w_to_cnt_next;
      r_rd_addr <= w_rd_addr_next;
      r_tx_data <= w_tx_data_next;
      r_tx_send <= w_tx_send_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
      r_err     <= w_err_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_len_next     = r_len;
    w_cnt_next     = r_cnt;
    w_csum_next    = r_csum;
    w_cs_sent_next = r_cs_sent;
    w_to_cnt_next  = r_to_cnt;
    w_rd_addr_next = r_rd_addr;
    w_tx_data_next = r_tx_data;
    w_tx_send_next = r_tx_send;
    w_busy_next    = r_busy;
    w_done_next    = 1'b0;
    w_err_next     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_len_bad) begin
            w_err_next = 1'b1;
          end else begin
            w_len_next     = length;
            w_csum_next    = length;
            w_tx_data_next = length;
            w_cnt_next     = '0;
            w_cs_sent_next = 1'b0;
            w_to_cnt_next  = '0;
            w_tx_send_next = 1'b1;
            w_busy_next    = 1'b1;
            w_state_next   = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        if (tx_busy) begin
          w_tx_send_next = 1'b0;
          w_state_next   = ST_WAIT_LO;
        end else if (r_to_cnt == TO_LAST) begin
          // Sender never acknowledged: abandon the frame, the host resynchronises.
          w_tx_send_next = 1'b0;
          w_err_next     = 1'b1;
          w_busy_next    = 1'b0;
          w_state_next   = ST_IDLE;
        end else begin
          w_to_cnt_next = r_to_cnt + 1'b1;
        end
      end

      ST_WAIT_LO: begin
        if (!tx_busy) begin
          if (r_cnt < r_len) begin
            w_rd_addr_next = r_cnt;
            w_state_next   = ST_FETCH;
          end else if (SEND_CHECKSUM && !r_cs_sent) begin
            w_tx_data_next = r_csum;
            w_cs_sent_next = 1'b1;
            w_to_cnt_next  = '0;
            w_tx_send_next = 1'b1;
            w_state_next   = ST_REQ;
          end else begin
            w_state_next = ST_FINISH;
          end
        end
      end

      ST_FETCH: w_state_next = ST_LOAD;

      ST_LOAD: begin
        w_tx_data_next = rd_data;
        w_csum_next    = r_csum ^ rd_data;
        w_cnt_next     = r_cnt + 8'd1;
        w_to_cnt_next  = '0;
        w_tx_send_next = 1'b1;
        w_state_next   = ST_REQ;
      end

      ST_FINISH: begin
        w_done_next  = 1'b1;
        w_busy_next  = 1'b0;
        w_state_next = ST_IDLE;
      end

      default: w_state_next = ST_IDLE;
    endcase
  end

  assign rd_addr = r_rd_addr;
  assign tx_data = r_tx_data;
  assign tx_send = r_tx_send;
  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;

endmodule

// File: tb/tb_dea_frame_tx.sv
// Directed bench for dea_frame_tx: instance 0 appends a checksum, instance 1 does not.
// Each has its own synchronous-read buffer port and behavioural UART_Sender.
module tb_dea_frame_tx;

  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start;
  logic [7:0] length;
  logic [7:0] rd_addr [2];
  logic [7:0] rd_data [2];
  logic [7:0] tx_data [2];
  logic [1:0] tx_send;
  logic [1:0] tx_busy = '0;
  logic [1:0] busy, done, err;

  logic [7:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  // Sender model state and transaction log, written only by the model process.
  int         cyc = 0;
  int         n_rx [2]       = '{0, 0};
  int         n_done [2]     = '{0, 0};
  int         n_err [2]      = '{0, 0};
  int         n_gap [2]      = '{0, 0};
  int         n_addr_chg [2] = '{0, 0};
  int         last_send_cyc [2] = '{0, 0};
  int         err_cyc [2]    = '{0, 0};
  int         phase [2]      = '{0, 0};
  int         dly [2]        = '{0, 0};
  logic       prev_send [2]  = '{1'b0, 1'b0};
  logic [7:0] prev_addr [2]  = '{8'h00, 8'h00};
  logic       in_frame [2]   = '{1'b0, 1'b0};
  logic [7:0] rx_log [2][64];
  logic       dead [2];

  always #5 clk = ~clk;

  dea_frame_tx #(
    .MAX_LEN(100), .SEND_CHECKSUM(1'b1), .TO_W(16), .TIMEOUT(16'(TO))
  ) u_dut_cs (
    .Clk_100M(clk), .Reset(rst), .start(start[0]), .length(length),
    .rd_addr(rd_addr[0]), .rd_data(rd_data[0]), .tx_data(tx_data[0]),
    .tx_send(tx_send[0]), .tx_busy(tx_busy[0]), .busy(busy[0]),
    .done(done[0]), .err(err[0])
  );

  dea_frame_tx #(
    .MAX_LEN(100), .SEND_CHECKSUM(1'b0), .TO_W(16), .TIMEOUT(16'(TO))
  ) u_dut_nc (
    .Clk_100M(clk), .Reset(rst), .start(start[1]), .length(length),
    .rd_addr(rd_addr[1]), .rd_data(rd_data[1]), .tx_data(tx_data[1]),
    .tx_send(tx_send[1]), .tx_busy(tx_busy[1]), .busy(busy[1]),
    .done(done[1]), .err(err[1])
  );

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) rd_data[k] <= mem[rd_addr[k]];
  end

  // UART_Sender: busy rises 2 cycles after a send request and stays high 20 cycles.
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (done[k]) n_done[k]++;
      if (err[k]) begin
        n_err[k]++;
        err_cyc[k] = cyc;
      end
      if (rd_addr[k] != prev_addr[k]) n_addr_chg[k]++;
      prev_addr[k] = rd_addr[k];
      if (done[k] || err[k] || rst) in_frame[k] = 1'b0;
      else if (in_frame[k] && !busy[k]) n_gap[k]++;
      if (rst) begin
        phase[k]   = 0;
        tx_busy[k] = 1'b0;
      end else begin
        case (phase[k])
          1: begin
            if (dly[k] == 0) begin
              tx_busy[k] = 1'b1;
              dly[k]     = 20;
              phase[k]   = 2;
            end else begin
              dly[k]--;
            end
          end
          2: begin
            dly[k]--;
            if (dly[k] == 0) begin
              tx_busy[k] = 1'b0;
              phase[k]   = 0;
            end
          end
          default: ;
        endcase
      end
      if (tx_send[k] && !prev_send[k]) begin
        if (n_rx[k] < 64) rx_log[k][n_rx[k]] = tx_data[k];
        n_rx[k]++;
        last_send_cyc[k] = cyc;
        in_frame[k]      = 1'b1;
        if (!dead[k] && phase[k] == 0 && !rst) begin
          phase[k] = 1;
          dly[k]   = 1;
        end
      end
      prev_send[k] = tx_send[k];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input int k, input logic [7:0] len);
    tick();
    length   = len;
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
  endtask

  task automatic wait_end(input int k, input int d0, input int e0, input string tag);
    int t;
    t = 0;
    while (n_done[k] == d0 && n_err[k] == e0 && t < 3000) begin
      tick();
      t++;
    end
    check({tag, " ended in time"}, (t < 3000) ? 1 : 0, 1);
  endtask

  task automatic wait_rx(input int k, input int target, input string tag);
    int t;
    t = 0;
    while (n_rx[k] < target && t < 3000) begin
      tick();
      t++;
    end
    check({tag, " byte seen in time"}, (t < 3000) ? 1 : 0, 1);
  endtask

  task automatic check_bytes(input int k, input int base, input int n,
                             input logic [7:0] e [8], input string tag);
    check({tag, " byte count"}, n_rx[k] - base, n);
    for (int i = 0; i < n && i < 8; i++) begin
      if (base + i < 64) check($sformatf("%s byte%0d", tag, i), rx_log[k][base + i], e[i]);
    end
    $display("frame %s: inst %0d, %0d bytes", tag, k, n_rx[k] - base);
  endtask

  initial begin
    int b, d0, e0, g0, a0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(8'h41 + i);
    dead[0] = 1'b0;
    dead[1] = 1'b0;
    rst     = 1'b1;
    start   = '0;
    length  = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("reset rd_addr", rd_addr[0], 8'h00);
    check("reset tx_data", tx_data[0], 8'h00);
    check("reset tx_send", tx_send[0], 0);
    check("reset busy", busy[0], 0);
    check("reset done", done[0], 0);
    check("reset err", err[0], 0);

    // Three-byte payload with checksum 03^41^42^43 = 43.
    b = n_rx[0]; d0 = n_done[0]; e0 = n_err[0]; g0 = n_gap[0];
    pulse_start(0, 8'd3);
    check("len3 busy after start", busy[0], 1);
    wait_end(0, d0, e0, "len3");
    repeat (5) tick();
    check_bytes(0, b, 5, '{8'h03, 8'h41, 8'h42, 8'h43, 8'h43, 8'h00, 8'h00, 8'h00}, "len3");
    check("len3 done pulses", n_done[0] - d0, 1);
    check("len3 busy gaps", n_gap[0] - g0, 0);
    check("len3 busy after done", busy[0], 0);

    // Header-only frame: checksum equals header 0x00, buffer untouched.
    b = n_rx[0]; d0 = n_done[0]; e0 = n_err[0]; a0 = n_addr_chg[0];
    pulse_start(0, 8'd0);
    wait_end(0, d0, e0, "len0");
    tick();
    check_bytes(0, b, 2, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, "len0");
    check("len0 done pulses", n_done[0] - d0, 1);
    check("len0 rd_addr changes", n_addr_chg[0] - a0, 0);

    // Illegal length.
    b = n_rx[0]; e0 = n_err[0];
    pulse_start(0, 8'd101);
    check("len101 err pulse", err[0], 1);
    check("len101 busy", busy[0], 0);
    tick();
    check("len101 err one cycle", err[0], 0);
    repeat (30) tick();
    check("len101 no send", n_rx[0] - b, 0);
    check("len101 err count", n_err[0] - e0, 1);
    check("len101 busy idle", busy[0], 0);

    // Handshake timeout, then recovery.
    dead[0] = 1'b1;
    b = n_rx[0]; d0 = n_done[0]; e0 = n_err[0];
    pulse_start(0, 8'd1);
    wait_end(0, d0, e0, "timeout");
    check("timeout err count", n_err[0] - e0, 1);
    check("timeout latency", err_cyc[0] - last_send_cyc[0], TO);
    check("timeout sends", n_rx[0] - b, 1);
    check("timeout tx_send", tx_send[0], 0);
    check("timeout busy", busy[0], 0);
    dead[0] = 1'b0;
    tick();
    b = n_rx[0]; d0 = n_done[0]; e0 = n_err[0];
    pulse_start(0, 8'd1);
    wait_end(0, d0, e0, "recover");
    tick();
    check_bytes(0, b, 3, '{8'h01, 8'h41, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, "recover");

    // Reset while the second payload byte is pending.
    b = n_rx[0]; d0 = n_done[0]; e0 = n_err[0];
    pulse_start(0, 8'd5);
    wait_rx(0, b + 3, "midreset");
    rst = 1'b1;
    tick();
    check("midreset tx_send", tx_send[0], 0);
    check("midreset busy", busy[0], 0);
    rst = 1'b0;
    repeat (40) tick();
    check("midreset no done", n_done[0] - d0, 0);
    check("midreset header", rx_log[0][b], 8'h05);
    b = n_rx[0]; d0 = n_done[0]; e0 = n_err[0];
    pulse_start(0, 8'd5);
    wait_end(0, d0, e0, "len5");
    tick();
    check_bytes(0, b, 7, '{8'h05, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h44, 8'h00}, "len5");

    // No checksum, with a second start ignored mid-frame.
    b = n_rx[1]; d0 = n_done[1]; e0 = n_err[1];
    pulse_start(1, 8'd2);
    wait_rx(1, b + 1, "nocs");
    pulse_start(1, 8'd7);
    wait_end(1, d0, e0, "nocs");
    repeat (80) tick();
    check_bytes(1, b, 3, '{8'h02, 8'h41, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, "nocs");
    check("nocs done pulses", n_done[1] - d0, 1);
    check("nocs busy", busy[1], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
